// File: rtl/nova_pkg.sv
// Shared constants and helpers for the register-file writeback controller.
package nova_pkg;

  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = $clog2(NREGS);
  localparam int unsigned DW    = 32;

  // Writeback source encodings; also the bit positions in valid/grant vectors.
  localparam logic WB_SRC_ALU = 1'b0;
  localparam logic WB_SRC_MEM = 1'b1;

  localparam logic [AW-1:0] ZERO_REG = '0;

  // r0 is never tracked, so it can never be a hazard.
  function automatic logic reg_hazard(input logic [AW-1:0]    r,
                                      input logic [NREGS-1:0] busy);
    return (r != ZERO_REG) && busy[r];
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_if.sv
// Issue, writeback and register-file write signals of the writeback controller.
interface regfile_wb_ctrl_if;
  import nova_pkg::*;

  logic             issue_valid;
  logic [AW-1:0]    issue_rs;
  logic [AW-1:0]    issue_rt;
  logic [AW-1:0]    issue_rd;
  logic             issue_stall;

  logic             alu_wb_valid;
  logic [AW-1:0]    alu_wb_rd;
  logic [DW-1:0]    alu_wb_data;
  logic             alu_wb_ready;

  logic             mem_wb_valid;
  logic [AW-1:0]    mem_wb_rd;
  logic [DW-1:0]    mem_wb_data;
  logic             mem_wb_ready;

  logic             rf_we;
  logic [AW-1:0]    rf_rd_addr;
  logic [DW-1:0]    rf_rd_data;
  logic [NREGS-1:0] busy_mask;
  logic             wb_err;

  // Decode/issue plus the writeback sources, observing the controller.
  modport master (
    output issue_valid, issue_rs, issue_rt, issue_rd,
    output alu_wb_valid, alu_wb_rd, alu_wb_data,
    output mem_wb_valid, mem_wb_rd, mem_wb_data,
    input  issue_stall, alu_wb_ready, mem_wb_ready,
    input  rf_we, rf_rd_addr, rf_rd_data, busy_mask, wb_err
  );

  // The controller itself.
  modport slave (
    input  issue_valid, issue_rs, issue_rt, issue_rd,
    input  alu_wb_valid, alu_wb_rd, alu_wb_data,
    input  mem_wb_valid, mem_wb_rd, mem_wb_data,
    output issue_stall, alu_wb_ready, mem_wb_ready,
    output rf_we, rf_rd_addr, rf_rd_data, busy_mask, wb_err
  );

endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter; the pointer only moves on contention.
module wb_rr_arbiter
  import nova_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;

  // Grant the lone requester, or the pointed-to one on contention.
  always_comb begin
    grant = valid;
    ptr_d = ptr_q;
    if (&valid) begin
      grant        = 2'b00;
      grant[ptr_q] = 1'b1;
      ptr_d        = ~ptr_q;
    end
  end

  // Pointer register, favouring the ALU out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= WB_SRC_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback arbitration, busy scoreboard and registered write port for the register file.
module regfile_wb_ctrl
  import nova_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  regfile_wb_ctrl_if.slave  bus
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             rf_we_q;
  logic [AW-1:0]    rf_addr_q;
  logic [DW-1:0]    rf_data_q;
  logic             wb_err_q;

  logic [1:0]       wb_valid, wb_grant;
  logic             xfer;
  logic [AW-1:0]    wb_rd;
  logic [DW-1:0]    wb_data;
  logic             issue_accept;

  assign wb_valid[WB_SRC_ALU] = bus.alu_wb_valid;
  assign wb_valid[WB_SRC_MEM] = bus.mem_wb_valid;

  wb_rr_arbiter u_arb (
    .clk   (clk),
    .reset (reset),
    .valid (wb_valid),
    .grant (wb_grant)
  );

  // Hazard detection on both sources (RAW) and the destination (WAW).
  always_comb begin
    bus.issue_stall = bus.issue_valid &
                      (reg_hazard(bus.issue_rs, busy_q) |
                       reg_hazard(bus.issue_rt, busy_q) |
                       reg_hazard(bus.issue_rd, busy_q));
    issue_accept    = bus.issue_valid & ~bus.issue_stall;
  end

  // Select the granted writeback source.
  always_comb begin
    xfer    = |wb_grant;
    wb_rd   = bus.alu_wb_rd;
    wb_data = bus.alu_wb_data;
    if (wb_grant[WB_SRC_MEM]) begin
      wb_rd   = bus.mem_wb_rd;
      wb_data = bus.mem_wb_data;
    end
  end

  // Scoreboard next state: clear on the file write, set on issue (set wins).
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_addr_q] = 1'b0;
    end
    if (issue_accept && (bus.issue_rd != ZERO_REG)) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  // Output stage, scoreboard and sticky error state.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      busy_q    <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      rf_we_q <= xfer && (wb_rd != ZERO_REG);
      if (xfer) begin
        rf_addr_q <= wb_rd;
        rf_data_q <= wb_data;
        // Writeback to a register nobody is waiting on.
        if ((wb_rd != ZERO_REG) && !busy_q[wb_rd]) begin
          wb_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.alu_wb_ready = wb_grant[WB_SRC_ALU];
  assign bus.mem_wb_ready = wb_grant[WB_SRC_MEM];
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_rd_addr   = rf_addr_q;
  assign bus.rf_rd_data   = rf_data_q;
  assign bus.busy_mask    = busy_q;
  assign bus.wb_err       = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios plus a randomized run against a reference model.
module tb_regfile_wb_ctrl;
  import nova_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  regfile_wb_ctrl_if bus ();

  regfile_wb_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file fed by the controller's write port.
  logic [DW-1:0] rf_mem [NREGS];
  always @(posedge clk) begin
    if (bus.rf_we) rf_mem[bus.rf_rd_addr] <= bus.rf_rd_data;
  end

  // Sources must hold valid/rd/data until ready.
  logic          alu_pend = 1'b0, mem_pend = 1'b0;
  logic [AW-1:0] alu_rd_h, mem_rd_h;
  logic [DW-1:0] alu_d_h, mem_d_h;
  always @(posedge clk) begin
    if (reset) begin
      alu_pend <= 1'b0;
      mem_pend <= 1'b0;
    end else begin
      if (alu_pend)
        assert (bus.alu_wb_valid && bus.alu_wb_rd == alu_rd_h && bus.alu_wb_data == alu_d_h)
          else $error("protocol: ALU source changed while not ready");
      if (mem_pend)
        assert (bus.mem_wb_valid && bus.mem_wb_rd == mem_rd_h && bus.mem_wb_data == mem_d_h)
          else $error("protocol: MEM source changed while not ready");
      alu_pend <= bus.alu_wb_valid && !bus.alu_wb_ready;
      mem_pend <= bus.mem_wb_valid && !bus.mem_wb_ready;
      alu_rd_h <= bus.alu_wb_rd;
      alu_d_h  <= bus.alu_wb_data;
      mem_rd_h <= bus.mem_wb_rd;
      mem_d_h  <= bus.mem_wb_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_valid  = 1'b0;
    bus.issue_rs     = '0;
    bus.issue_rt     = '0;
    bus.issue_rd     = '0;
    bus.alu_wb_valid = 1'b0;
    bus.alu_wb_rd    = '0;
    bus.alu_wb_data  = '0;
    bus.mem_wb_valid = 1'b0;
    bus.mem_wb_rd    = '0;
    bus.mem_wb_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic issue(input int rs, input int rt, input int rd);
    bus.issue_valid = 1'b1;
    bus.issue_rs    = AW'(rs);
    bus.issue_rt    = AW'(rt);
    bus.issue_rd    = AW'(rd);
  endtask

  // ---------------- reference model ----------------
  bit            m_busy [NREGS];
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  bit            m_err;
  bit            m_turn_mem;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_we = 0; m_addr = '0; m_data = '0; m_err = 0; m_turn_mem = 0;
  endtask

  function automatic bit m_hz(input logic [AW-1:0] r);
    return (r != 0) && m_busy[r];
  endfunction

  function automatic logic [NREGS-1:0] m_mask();
    logic [NREGS-1:0] m = '0;
    for (int i = 1; i < NREGS; i++) m[i] = m_busy[i];
    return m;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    tick();
    vectors++; if (bus.rf_we !== 1'b0) begin miscompares++;
      $display("FAIL reset_rf_we: got %b want 0", bus.rf_we); end
    vectors++; if (bus.busy_mask !== '0) begin miscompares++;
      $display("FAIL reset_busy: got %h want 0", bus.busy_mask); end
    vectors++; if (bus.wb_err !== 1'b0) begin miscompares++;
      $display("FAIL reset_err: got %b want 0", bus.wb_err); end
    vectors++; if (bus.rf_rd_addr !== '0 || bus.rf_rd_data !== '0) begin miscompares++;
      $display("FAIL reset_rf_out: got %h/%h want 0/0", bus.rf_rd_addr, bus.rf_rd_data); end
    issue(1, 2, 3);
    #1;
    vectors++; if (bus.issue_stall !== 1'b0) begin miscompares++;
      $display("FAIL first_issue_stall: got %b want 0", bus.issue_stall); end
    tick();
    bus.issue_valid = 1'b0;
    vectors++; if (bus.busy_mask !== 32'h0000_0008) begin miscompares++;
      $display("FAIL first_issue_busy: got %h want 00000008", bus.busy_mask); end
  endtask

  task automatic test_raw();
    issue(0, 0, 5);
    #1;
    vectors++; if (bus.issue_stall !== 1'b0) begin miscompares++;
      $display("FAIL raw_issue_rd5: got %b want 0", bus.issue_stall); end
    tick();
    vectors++; if (bus.busy_mask !== 32'h0000_0028) begin miscompares++;
      $display("FAIL raw_busy: got %h want 00000028", bus.busy_mask); end
    issue(5, 0, 6);
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd5; bus.alu_wb_data = 32'hDEAD_BEEF;
    #1;
    vectors++; if (bus.issue_stall !== 1'b1) begin miscompares++;
      $display("FAIL raw_stall: got %b want 1", bus.issue_stall); end
    vectors++; if (bus.alu_wb_ready !== 1'b1 || bus.mem_wb_ready !== 1'b0) begin miscompares++;
      $display("FAIL raw_alu_ready: got %b%b want 10", bus.alu_wb_ready, bus.mem_wb_ready); end
    tick();
    bus.alu_wb_valid = 1'b0;
    #1;
    vectors++; if (bus.rf_we !== 1'b1 || bus.rf_rd_addr !== 5'd5 || bus.rf_rd_data !== 32'hDEAD_BEEF)
      begin miscompares++;
      $display("FAIL raw_rf_write: got %b/%0d/%h want 1/5/deadbeef",
               bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data); end
    vectors++; if (bus.issue_stall !== 1'b1) begin miscompares++;
      $display("FAIL raw_stall_held: got %b want 1", bus.issue_stall); end
    tick();
    vectors++; if (bus.issue_stall !== 1'b0) begin miscompares++;
      $display("FAIL raw_stall_release: got %b want 0", bus.issue_stall); end
    vectors++; if (rf_mem[5] !== 32'hDEAD_BEEF) begin miscompares++;
      $display("FAIL raw_regfile_r5: got %h want deadbeef", rf_mem[5]); end
    vectors++; if (bus.rf_we !== 1'b0 || bus.busy_mask !== 32'h0000_0008) begin miscompares++;
      $display("FAIL raw_retire: got we=%b busy=%h want 0/00000008", bus.rf_we, bus.busy_mask); end
    bus.issue_valid = 1'b0;
  endtask

  task automatic test_contention();
    issue(0, 0, 4);
    tick();
    bus.issue_valid = 1'b0;
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd3; bus.alu_wb_data = 32'h1111_1111;
    bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = 5'd4; bus.mem_wb_data = 32'h2222_2222;
    #1;
    vectors++; if (bus.alu_wb_ready !== 1'b1 || bus.mem_wb_ready !== 1'b0) begin miscompares++;
      $display("FAIL cont_grant1: got %b%b want 10", bus.alu_wb_ready, bus.mem_wb_ready); end
    tick();
    vectors++; if (bus.rf_rd_addr !== 5'd3 || bus.rf_rd_data !== 32'h1111_1111) begin miscompares++;
      $display("FAIL cont_addr1: got %0d/%h want 3/11111111", bus.rf_rd_addr, bus.rf_rd_data); end
    bus.alu_wb_data = 32'h3333_3333;
    #1;
    vectors++; if (bus.alu_wb_ready !== 1'b0 || bus.mem_wb_ready !== 1'b1) begin miscompares++;
      $display("FAIL cont_grant2: got %b%b want 01", bus.alu_wb_ready, bus.mem_wb_ready); end
    tick();
    vectors++; if (bus.rf_rd_addr !== 5'd4 || bus.wb_err !== 1'b0) begin miscompares++;
      $display("FAIL cont_addr2: got %0d err=%b want 4 err=0", bus.rf_rd_addr, bus.wb_err); end
    #1;
    vectors++; if (bus.alu_wb_ready !== 1'b1 || bus.mem_wb_ready !== 1'b0) begin miscompares++;
      $display("FAIL cont_grant3: got %b%b want 10", bus.alu_wb_ready, bus.mem_wb_ready); end
    tick();
    vectors++; if (bus.rf_rd_addr !== 5'd3 || bus.rf_rd_data !== 32'h3333_3333) begin miscompares++;
      $display("FAIL cont_addr3: got %0d/%h want 3/33333333", bus.rf_rd_addr, bus.rf_rd_data); end
    vectors++; if (bus.wb_err !== 1'b1) begin miscompares++;
      $display("FAIL cont_wb_err: got %b want 1", bus.wb_err); end
    bus.alu_wb_valid = 1'b0;
    #1;
    vectors++; if (bus.mem_wb_ready !== 1'b1) begin miscompares++;
      $display("FAIL cont_mem_alone: got %b want 1", bus.mem_wb_ready); end
    tick();
    bus.mem_wb_valid = 1'b0;
  endtask

  task automatic test_waw();
    do_reset();
    issue(0, 0, 7);
    tick();
    #1;
    vectors++; if (bus.issue_stall !== 1'b1) begin miscompares++;
      $display("FAIL waw_stall: got %b want 1", bus.issue_stall); end
    tick();
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd7; bus.alu_wb_data = 32'h0000_1234;
    #1;
    vectors++; if (bus.alu_wb_ready !== 1'b1) begin miscompares++;
      $display("FAIL waw_alu_ready: got %b want 1", bus.alu_wb_ready); end
    tick();
    bus.alu_wb_valid = 1'b0;
    #1;
    vectors++; if (bus.issue_stall !== 1'b1) begin miscompares++;
      $display("FAIL waw_stall_pending: got %b want 1", bus.issue_stall); end
    tick();
    vectors++; if (bus.issue_stall !== 1'b0 || bus.busy_mask !== '0) begin miscompares++;
      $display("FAIL waw_release: got stall=%b busy=%h want 0/0", bus.issue_stall, bus.busy_mask); end
    tick();
    bus.issue_valid = 1'b0;
    vectors++; if (bus.busy_mask !== 32'h0000_0080 || bus.wb_err !== 1'b0) begin miscompares++;
      $display("FAIL waw_reissue: got busy=%h err=%b want 00000080/0", bus.busy_mask, bus.wb_err); end
  endtask

  task automatic test_rd_zero();
    do_reset();
    issue(0, 0, 9);
    tick();
    bus.issue_valid = 1'b0;
    bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = '0; bus.mem_wb_data = 32'hFFFF_FFFF;
    #1;
    vectors++; if (bus.mem_wb_ready !== 1'b1) begin miscompares++;
      $display("FAIL rd0_ready: got %b want 1", bus.mem_wb_ready); end
    tick();
    bus.mem_wb_valid = 1'b0;
    vectors++; if (bus.rf_we !== 1'b0 || bus.busy_mask !== 32'h0000_0200 || bus.wb_err !== 1'b0)
      begin miscompares++;
      $display("FAIL rd0_effect: got we=%b busy=%h err=%b want 0/00000200/0",
               bus.rf_we, bus.busy_mask, bus.wb_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(0, 0, 1); tick();
    issue(0, 0, 2); tick();
    bus.issue_valid = 1'b0;
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd1; bus.alu_wb_data = 32'hA5A5_0001;
    bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = 5'd2; bus.mem_wb_data = 32'hA5A5_0002;
    tick();
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    vectors++; if (bus.rf_we !== 1'b0 || bus.busy_mask !== '0) begin miscompares++;
      $display("FAIL midreset_state: got we=%b busy=%h want 0/0", bus.rf_we, bus.busy_mask); end
    issue(0, 0, 1); tick();
    issue(0, 0, 2); tick();
    bus.issue_valid = 1'b0;
    bus.alu_wb_valid = 1'b1; bus.alu_wb_rd = 5'd1; bus.alu_wb_data = 32'h0000_0011;
    bus.mem_wb_valid = 1'b1; bus.mem_wb_rd = 5'd2; bus.mem_wb_data = 32'h0000_0022;
    #1;
    vectors++; if (bus.alu_wb_ready !== 1'b1 || bus.mem_wb_ready !== 1'b0) begin miscompares++;
      $display("FAIL midreset_ptr: got %b%b want 10", bus.alu_wb_ready, bus.mem_wb_ready); end
    tick();
    bus.alu_wb_valid = 1'b0;
    tick();
    bus.mem_wb_valid = 1'b0;
  endtask

  task automatic test_random();
    bit               alu_hold = 0, mem_hold = 0;
    bit               e_stall, g_alu, g_mem, acc;
    logic [AW-1:0]    w_rd;
    logic [DW-1:0]    w_data;
    logic [NREGS-1:0] e_mask;
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      if (!alu_hold) begin
        bus.alu_wb_valid = ($urandom_range(0, 2) == 0);
        bus.alu_wb_rd    = AW'($urandom_range(0, 7));
        bus.alu_wb_data  = DW'($urandom);
      end
      if (!mem_hold) begin
        bus.mem_wb_valid = ($urandom_range(0, 2) == 0);
        bus.mem_wb_rd    = AW'($urandom_range(0, 7));
        bus.mem_wb_data  = DW'($urandom);
      end
      issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      bus.issue_valid = ($urandom_range(0, 1) == 1);
      #1;
      e_stall = bus.issue_valid && (m_hz(bus.issue_rs) || m_hz(bus.issue_rt) || m_hz(bus.issue_rd));
      if (bus.alu_wb_valid && bus.mem_wb_valid) begin
        g_alu = !m_turn_mem;
        g_mem = m_turn_mem;
        m_turn_mem = !m_turn_mem;
      end else begin
        g_alu = bus.alu_wb_valid;
        g_mem = bus.mem_wb_valid;
      end
      vectors++; if (bus.issue_stall !== e_stall) begin miscompares++;
        $display("FAIL rnd_stall c=%0d: got %b want %b", c, bus.issue_stall, e_stall); end
      vectors++; if (bus.alu_wb_ready !== g_alu) begin miscompares++;
        $display("FAIL rnd_alu_ready c=%0d: got %b want %b", c, bus.alu_wb_ready, g_alu); end
      vectors++; if (bus.mem_wb_ready !== g_mem) begin miscompares++;
        $display("FAIL rnd_mem_ready c=%0d: got %b want %b", c, bus.mem_wb_ready, g_mem); end
      // Advance the model by one clock edge.
      acc = bus.issue_valid && !e_stall;
      w_rd   = g_mem ? bus.mem_wb_rd : bus.alu_wb_rd;
      w_data = g_mem ? bus.mem_wb_data : bus.alu_wb_data;
      if ((g_alu || g_mem) && w_rd != 0 && !m_busy[w_rd]) m_err = 1;
      if (m_we) m_busy[m_addr] = 0;
      if (g_alu || g_mem) begin
        m_we = (w_rd != 0); m_addr = w_rd; m_data = w_data;
      end else begin
        m_we = 0;
      end
      if (acc && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1;
      alu_hold = bus.alu_wb_valid && !g_alu;
      mem_hold = bus.mem_wb_valid && !g_mem;
      tick();
      e_mask = m_mask();
      vectors++; if (bus.rf_we !== m_we) begin miscompares++;
        $display("FAIL rnd_rf_we c=%0d: got %b want %b", c, bus.rf_we, m_we); end
      vectors++; if (bus.rf_rd_addr !== m_addr) begin miscompares++;
        $display("FAIL rnd_rf_addr c=%0d: got %0d want %0d", c, bus.rf_rd_addr, m_addr); end
      vectors++; if (bus.rf_rd_data !== m_data) begin miscompares++;
        $display("FAIL rnd_rf_data c=%0d: got %h want %h", c, bus.rf_rd_data, m_data); end
      vectors++; if (bus.busy_mask !== e_mask) begin miscompares++;
        $display("FAIL rnd_busy c=%0d: got %h want %h", c, bus.busy_mask, e_mask); end
      vectors++; if (bus.wb_err !== m_err) begin miscompares++;
        $display("FAIL rnd_wb_err c=%0d: got %b want %b", c, bus.wb_err, m_err); end
    end
    // Let held sources drain before leaving.
    bus.issue_valid = 1'b0;
    for (int k = 0; k < 4 && (alu_hold || mem_hold); k++) begin
      #1;
      if (bus.alu_wb_ready) alu_hold = 0;
      if (bus.mem_wb_ready) mem_hold = 0;
      tick();
      if (!alu_hold) bus.alu_wb_valid = 1'b0;
      if (!mem_hold) bus.mem_wb_valid = 1'b0;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_raw();
    test_contention();
    test_waw();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Controller in front of the 32x32 register file's single write port and its two combinational read ports. Arbitrates two writeback sources (ALU, MEM) onto the one write port. Keeps a busy scoreboard of registers with outstanding writes and stalls issue on RAW and WAW hazards. Sits between decode/issue and the register file; drives the file's we/rd_addr/rd_data inputs directly.

Parameters:
NREGS, 32, number of architectural registers; r0 is never tracked or written.
AW, 5, register address width, equal to log2(NREGS).
DW, 32, data width.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
issue_valid  in  1  decode presents an instruction
issue_rs  in  AW  source register 1
issue_rt  in  AW  source register 2
issue_rd  in  AW  destination register; 0 means no write
issue_stall  out  1  combinational; 1 means the instruction is not accepted this cycle
alu_wb_valid  in  1  ALU result available
alu_wb_rd  in  AW  ALU destination
alu_wb_data  in  DW  ALU result
alu_wb_ready  out  1  ALU result accepted this cycle
mem_wb_valid  in  1  MEM result available
mem_wb_rd  in  AW  MEM destination
mem_wb_data  in  DW  MEM result
mem_wb_ready  out  1  MEM result accepted this cycle
rf_we  out  1  register-file write enable (registered)
rf_rd_addr  out  AW  register-file write address (registered)
rf_rd_data  out  DW  register-file write data (registered)
busy_mask  out  NREGS  scoreboard state; bit 0 is always 0
wb_err  out  1  sticky flag: a writeback targeted a non-busy register

Behaviour:
- Reset, synchronous: rf_we=0, rf_rd_addr=0, rf_rd_data=0, busy_mask=0, wb_err=0, round-robin pointer=ALU. All in-flight state is discarded, including during an active arbitration.
- Hazard check, combinational: hz(x) = (x!=0) && busy[x].
- issue_stall = issue_valid && (hz(rs) || hz(rt) || hz(rd)).
- issue_stall is 0 whenever issue_valid is 0.
- Issue accepted when issue_valid && !issue_stall. If rd!=0, busy[rd] is set at that edge.
- Arbitration, combinational:
  - Only one valid source: that source is granted.
  - Both valid: the source named by the pointer is granted, and the pointer flips to the other source at that edge.
  - The pointer does not move when there is no contention.
- alu_wb_ready / mem_wb_ready = grant for that source.
- At most one ready is high per cycle. Ready never asserts without the matching valid.
- The output stage drains every cycle, so a granted transfer completes in the same cycle.
- Latency: transfer at edge N → at edge N, rf_we <= (rd!=0), rf_rd_addr <= rd, rf_rd_data <= data. The register-file write happens at edge N+1.
- No transfer at edge N → rf_we <= 0. Address and data hold their previous values.
- Scoreboard clear: on the rf_we edge (edge N+1), busy[rf_rd_addr] is cleared.
  - An issue read in the cycle after that edge sees the new value, because the register-file reads are combinational.
  - The stall releases in the same cycle the written value becomes readable. No forwarding path.
- Set and clear of the same register in the same edge cannot occur, because issue stalls on hz(rd). The implementation still gives set priority.
- Writeback with rd=0: accepted (ready=1), rf_we stays 0, scoreboard unchanged.
- Writeback whose rd is not busy when accepted: accepted, written normally, wb_err is set and held until reset.
- Sources must hold valid/rd/data stable until ready. A change while not ready is a protocol violation; the bench asserts on it.

Decomposition:
- Shared package (nova_pkg): NREGS/AW/DW constants, WB_SRC_ALU=0 and WB_SRC_MEM=1 encodings, and the zero-register constant.
- One sub-module, wb_rr_arbiter: 2-way round-robin with pointer register, inputs valid[1:0], outputs grant[1:0].
- The scoreboard and the output register stay in the top level.

Test Plan:
- Reset then idle → rf_we=0, busy_mask=0, issue of rs=1/rt=2/rd=3 accepted with stall=0; busy_mask=0x00000008 the next cycle.
- Issue rd=5, then an instruction with rs=5 → stall=1. ALU writeback rd=5 data=0xDEADBEEF accepted at edge N → rf_we=1 with addr 5 in cycle N+1. Stall drops the cycle after edge N+1; regfile r5 = 0xDEADBEEF.
- ALU (rd=3) and MEM (rd=4) valid together for 3 cycles, both busy and re-presented each time:
  - grants are ALU, MEM, ALU;
  - rf_rd_addr sequence is 3, 4, 3;
  - wb_err=1 after the third write.
- WAW: rd=7 busy, issue rd=7 with rs=rt=0 → stall=1 until the writeback of r7 retires; then accepted and busy[7]=1 again.
- MEM writeback rd=0 data=0xFFFFFFFF → mem_wb_ready=1, rf_we stays 0, busy_mask unchanged, wb_err=0.
- Reset asserted one cycle after a transfer is accepted → next cycle rf_we=0, busy_mask=0, pointer=ALU; a later ALU/MEM contention grants ALU first.
